// File: rtl/fetch_unit_pkg.sv
// Shared widths, depths and the buffered {pc, instr} entry type for the fetch unit slice.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned FETCH_DEPTH = 2;
  localparam int unsigned CNT_W       = $clog2(FETCH_DEPTH + 1);

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, redirect and instruction-delivery signals of the fetch unit.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  // Fetch unit side: drives the memory address and the instruction stream.
  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  // Environment side: memory, redirect source and instruction consumer.
  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry in-order buffer of fetched {pc, instr}; pop is applied before push, flush overrides push.
module fetch_skid_fifo
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fetch_entry_t     push_entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     slot_q [FETCH_DEPTH];
  fetch_entry_t     slot_d [FETCH_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_pop;
  logic             pop_ok;

  always_comb begin
    slot_d    = slot_q;
    pop_ok    = pop_i && (count_q != '0);
    count_pop = count_q - CNT_W'(pop_ok);
    if (pop_ok) begin
      slot_d[0] = slot_q[1];
    end
    count_d = count_pop;
    // Slot 0 is always the head, so a push lands just behind whatever survives the pop.
    if (flush_i) begin
      count_d = '0;
    end else if (push_i && (count_pop < CNT_W'(FETCH_DEPTH))) begin
      if (count_pop == '0) begin
        slot_d[0] = push_entry_i;
      end else begin
        slot_d[1] = push_entry_i;
      end
      count_d = count_pop + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int unsigned i = 0; i < FETCH_DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      slot_q  <= slot_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with one outstanding memory read, a 2-entry output buffer and redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    occupancy;
  logic [ADDR_W-1:0] redirect_aligned;

  assign bus.instr_valid = (fifo_count != '0);
  assign pop             = bus.instr_valid && bus.instr_ready;
  assign redirect_aligned = bus.redirect_pc & ~ADDR_W'(3);

  // Occupancy counts buffered plus in-flight words, so a new issue never outruns buffer space.
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
  assign issue     = !bus.redirect_valid &&
                     (occupancy <= ((CNT_W + 1)'(1) + (CNT_W + 1)'(pop)));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (bus.redirect_valid) begin
      pc_d = redirect_aligned;
    end else if (issue) begin
      pc_d          = pc_q + ADDR_W'(4);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push             = inflight_q && !bus.redirect_valid;
  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = bus.imem_data;

  fetch_skid_fifo u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (bus.redirect_valid),
    .count_o      (fifo_count),
    .head_o       (head)
  );

  assign bus.imem_addr = pc_q;
  assign bus.instr     = head.instr;
  assign bus.instr_pc  = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle bench for fetch_unit: streaming, stalls, redirects, wrap and mid-stream reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] eaddr;
    logic [31:0] einstr;
    logic [31:0] epc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  vec_t vecs[$];

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00: mem_word = 32'h002300AA;
      32'h04: mem_word = 32'h10654321;
      32'h08: mem_word = 32'h00100022;
      32'h0C: mem_word = 32'h8C123456;
      32'h10: mem_word = 32'h8F123456;
      32'h14: mem_word = 32'hAD654321;
      32'h18: mem_word = 32'h13012345;
      32'h1C: mem_word = 32'hAC654321;
      32'h20: mem_word = 32'h12012345;
      32'h24: mem_word = 32'h12012345;
      default: mem_word = ~a;
    endcase
  endfunction

  // One-cycle read latency memory.
  always @(posedge clk) bus.imem_data <= mem_word(bus.imem_addr);

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] eaddr,
                              input logic [31:0] einstr, input logic [31:0] epc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.eaddr = eaddr; v.einstr = einstr; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic chk_outputs(input string tag, input logic ev, input logic [31:0] eaddr,
                             input logic [31:0] einstr, input logic [31:0] epc);
    chk({tag, ".imem_addr"}, bus.imem_addr, eaddr);
    chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(ev));
    if (ev) begin
      chk({tag, ".instr"}, bus.instr, einstr);
      chk({tag, ".instr_pc"}, bus.instr_pc, epc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;

    //              rdy rv  rpc           ev  addr          instr         pc
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h00,       32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h04,       32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h08,       32'h002300AA, 32'h00));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h0C,       32'h10654321, 32'h04));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h10,       32'h00100022, 32'h08));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h14,       32'h8C123456, 32'h0C));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h14,       32'h8C123456, 32'h0C));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h14,       32'h8C123456, 32'h0C));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h14,       32'h8C123456, 32'h0C));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h14,       32'h8C123456, 32'h0C));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h14,       32'h8C123456, 32'h0C));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h18,       32'h8F123456, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h1C,       32'hAD654321, 32'h14));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h20,       32'h13012345, 32'h18));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h24,       32'hAC654321, 32'h1C));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h28,       32'h12012345, 32'h20));
    vecs.push_back(mk(1, 1, 32'h1E,       1, 32'h2C,       32'h12012345, 32'h24));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h1C,       32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h20,       32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h24,       32'hAC654321, 32'h1C));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h28,       32'h12012345, 32'h20));
    vecs.push_back(mk(0, 1, 32'h08,       1, 32'h28,       32'h12012345, 32'h20));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h08,       32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0C,       32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 32'hFFFFFFFC, 1, 32'h10,       32'h00100022, 32'h08));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'hFFFFFFFC, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h00,       32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h04,       32'h00000003, 32'hFFFFFFFC));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h08,       32'h002300AA, 32'h00));
    vecs.push_back(mk(1, 1, 32'h14,       1, 32'h0C,       32'h10654321, 32'h04));
    vecs.push_back(mk(1, 1, 32'h1D,       0, 32'h14,       32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h1C,       32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h20,       32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h24,       32'hAC654321, 32'h1C));

    // Reset-state outputs while reset is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.imem_addr",   bus.imem_addr, 32'h0);
    chk("rst.instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst.instr",       bus.instr, 32'h0);
    chk("rst.instr_pc",    bus.instr_pc, 32'h0);

    rst_n = 1'b1;
    foreach (vecs[i]) begin
      bus.instr_ready    = vecs[i].rdy;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      chk_outputs($sformatf("cyc%0d", i), vecs[i].ev, vecs[i].eaddr, vecs[i].einstr, vecs[i].epc);
      @(posedge clk);
      #1;
    end

    // Mid-stream reset with the buffer full and the consumer stalled.
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    #3;
    chk_outputs("full", 1'b1, 32'h24, 32'hAC654321, 32'h1C);
    rst_n = 1'b0;
    #1;
    chk("midrst.instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("midrst.imem_addr",   bus.imem_addr, 32'h0);
    chk("midrst.instr",       bus.instr, 32'h0);
    chk("midrst.instr_pc",    bus.instr_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n           = 1'b1;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [31:0] pc_exp;
      pc_exp = 32'(k - 2) * 32'd4;
      @(negedge clk);
      chk_outputs($sformatf("restart%0d", k), k >= 2, 32'(k) * 32'd4, mem_word(pc_exp), pc_exp);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
